// File: rtl/pdm_audio_sequencer.sv
// Mixes NCH unsigned channels into one DEPTH-bit sample and paces it with a sample tick.
// Applies a linear anti-pop gain ramp and drives the PDM modulator sample/enable inputs.
module pdm_audio_sequencer #(
   parameter int DEPTH    = 8,
   parameter int NCH      = 4,
   parameter int TICK_DIV = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   audio_on,
   input  logic [NCH*DEPTH-1:0]   ch_sample,
   input  logic [NCH-1:0]         ch_valid,
   output logic [NCH-1:0]         ch_ready,
   input  logic [NCH-1:0]         ch_mute,
   input  logic                   underrun_clr,
   output logic [NCH-1:0]         underrun,
   output logic                   tick,
   output logic [1:0]             state,
   output logic [DEPTH-1:0]       pdm_sample,
   output logic                   pdm_en
);

   localparam int LOG = $clog2(NCH);
   localparam int SW  = DEPTH + LOG;
   localparam int CW  = $clog2(TICK_DIV);
   localparam logic [DEPTH:0] G_ONE = (DEPTH+1)'(1);
   localparam logic [DEPTH:0] UNITY = (DEPTH+1)'(1) << DEPTH;

   typedef enum logic [1:0] {OFF = 2'd0, RAMP_UP = 2'd1, ON = 2'd2, RAMP_DOWN = 2'd3} state_t;

   state_t              st;
   logic [CW-1:0]       count;
   logic [DEPTH-1:0]    hold [NCH];
   logic [NCH-1:0]      fresh;
   logic [NCH-1:0]      cap;
   logic [NCH-1:0]      set_mask;
   logic [SW-1:0]       sum;
   logic [DEPTH-1:0]    mix_r;
   logic [DEPTH:0]      g;
   logic                tick_d;
   logic [2*DEPTH:0]    prod;

   assign tick     = (count == CW'(TICK_DIV - 1));
   assign ch_ready = ~fresh;
   assign cap      = ch_valid & ~fresh;
   assign state    = st;
   assign pdm_en   = (st != OFF);
   assign prod     = {{(DEPTH+1){1'b0}}, mix_r} * {{DEPTH{1'b0}}, g};

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || tick) count <= '0;
      else             count <= count + 1'b1;
   end

   // NOTE: the sample holds are reset too, so a channel that never posts mixes in as silence.
   always_ff @(posedge clk) begin
      if (rst) begin
         fresh <= '0;
         for (int i = 0; i < NCH; i++) hold[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (cap[i]) begin
               hold[i]  <= ch_sample[i*DEPTH +: DEPTH];
               fresh[i] <= 1'b1;
            end else if (tick) begin
               fresh[i] <= 1'b0;
            end
         end
      end
   end

   // NOTE: combinational blocks assign a default first so no latch is inferred.
   always_comb begin
      sum = '0;
      for (int i = 0; i < NCH; i++)
         if (!ch_mute[i]) sum = sum + SW'(hold[i]);
   end

   always_comb begin
      set_mask = '0;
      if (tick && st != OFF) set_mask = ~fresh & ~ch_mute;
   end

   // Set takes priority over a coincident clear.
   always_ff @(posedge clk) begin
      if (rst) underrun <= '0;
      else     underrun <= (underrun & ~{NCH{underrun_clr}}) | set_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= OFF;
         g     <= '0;
         mix_r <= '0;
      end else if (tick) begin
         mix_r <= DEPTH'(sum >> LOG);
         unique case (st)
            OFF: if (audio_on) begin
               st <= RAMP_UP;
               g  <= G_ONE;
            end
            RAMP_UP: if (!audio_on) begin
               st <= RAMP_DOWN;
               g  <= g - G_ONE;
            end else begin
               g <= g + G_ONE;
               if (g == UNITY - G_ONE) st <= ON;
            end
            ON: if (!audio_on) begin
               st <= RAMP_DOWN;
               g  <= g - G_ONE;
            end
            RAMP_DOWN: if (audio_on) begin
               st <= RAMP_UP;
               g  <= g + G_ONE;
            end else if (g <= G_ONE) begin
               // Saturates at zero so a reversal right after g=1 cannot wrap.
               st <= OFF;
               g  <= '0;
            end else begin
               g <= g - G_ONE;
            end
            default: st <= OFF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_d     <= 1'b0;
         pdm_sample <= '0;
      end else begin
         tick_d <= tick;
         if (tick_d) pdm_sample <= DEPTH'(prod >> DEPTH);
      end
   end

endmodule

// File: tb/tb_pdm_audio_sequencer.sv
// Randomized and directed bench for pdm_audio_sequencer against a behavioural per-cycle model.
module tb_pdm_audio_sequencer;

   localparam int DEPTH    = 8;
   localparam int NCH      = 4;
   localparam int TICK_DIV = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 audio_on;
   logic [NCH*DEPTH-1:0] ch_sample;
   logic [NCH-1:0]       ch_valid;
   logic [NCH-1:0]       ch_ready;
   logic [NCH-1:0]       ch_mute;
   logic                 underrun_clr;
   logic [NCH-1:0]       underrun;
   logic                 tick;
   logic [1:0]           state;
   logic [DEPTH-1:0]     pdm_sample;
   logic                 pdm_en;

   pdm_audio_sequencer #(.DEPTH(DEPTH), .NCH(NCH), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst(rst), .audio_on(audio_on), .ch_sample(ch_sample),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_mute(ch_mute),
      .underrun_clr(underrun_clr), .underrun(underrun), .tick(tick),
      .state(state), .pdm_sample(pdm_sample), .pdm_en(pdm_en)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Reference model: plain integers following the behavioural rules.
   int m_count, m_mix, m_g, m_state, m_tick_d, m_sample;
   int m_hold [NCH];
   int m_fresh[NCH];
   int m_under[NCH];

   logic [7:0]     feed [NCH];
   logic [NCH-1:0] post;
   bit             feed_mode;

   task automatic model_edge();
      int tk, sum;
      if (rst) begin
         m_count = 0; m_mix = 0; m_g = 0; m_state = 0; m_tick_d = 0; m_sample = 0;
         for (int i = 0; i < NCH; i++) begin m_hold[i] = 0; m_fresh[i] = 0; m_under[i] = 0; end
         return;
      end
      tk = (m_count == TICK_DIV - 1);
      if (m_tick_d) m_sample = (m_mix * m_g) / (1 << DEPTH);
      m_tick_d = tk;
      if (underrun_clr) for (int i = 0; i < NCH; i++) m_under[i] = 0;
      if (tk) begin
         sum = 0;
         for (int i = 0; i < NCH; i++) if (!ch_mute[i]) sum += m_hold[i];
         if (m_state != 0)
            for (int i = 0; i < NCH; i++) if (!ch_mute[i] && !m_fresh[i]) m_under[i] = 1;
         case (m_state)
            0: if (audio_on) begin m_state = 1; m_g = 1; end
            1: if (!audio_on) begin m_state = 3; m_g = m_g - 1; end
               else begin m_g = m_g + 1; if (m_g == 256) m_state = 2; end
            2: if (!audio_on) begin m_state = 3; m_g = m_g - 1; end
            default: if (audio_on) begin m_state = 1; m_g = m_g + 1; end
               else begin m_g = (m_g > 0) ? m_g - 1 : 0; if (m_g == 0) m_state = 0; end
         endcase
         m_mix = sum / NCH;
      end
      for (int i = 0; i < NCH; i++) begin
         if (ch_valid[i] && !m_fresh[i]) begin
            m_hold[i]  = ch_sample[i*DEPTH +: DEPTH];
            m_fresh[i] = 1;
         end else if (tk) m_fresh[i] = 0;
      end
      m_count = tk ? 0 : m_count + 1;
   endtask

   task automatic compare_all();
      logic [NCH-1:0] er, eu;
      for (int i = 0; i < NCH; i++) begin er[i] = (m_fresh[i] == 0); eu[i] = (m_under[i] != 0); end
      check("tick",       int'(tick),       int'(m_count == TICK_DIV - 1));
      check("ch_ready",   int'(ch_ready),   int'(er));
      check("underrun",   int'(underrun),   int'(eu));
      check("state",      int'(state),      m_state);
      check("pdm_en",     int'(pdm_en),     int'(m_state != 0));
      check("pdm_sample", int'(pdm_sample), m_sample);
   endtask

   // One clock: apply inputs, advance the model, then compare on the falling edge.
   task automatic cycle();
      if (feed_mode) begin
         ch_valid = post;
         for (int i = 0; i < NCH; i++) ch_sample[i*DEPTH +: DEPTH] = feed[i];
      end
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run_to_tick();
      for (int i = 0; i < TICK_DIV && m_count != TICK_DIV - 1; i++) cycle();
   endtask

   // Pass n ticks, then one more cycle so pdm_sample shows the last tick's result.
   task automatic after_ticks(input int n);
      for (int k = 0; k < n; k++) begin run_to_tick(); cycle(); end
      cycle();
   endtask

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, nticks, cnt, n, en_at_tick;
      logic [7:0] prev;
      rst = 1'b1; audio_on = 1'b0; ch_sample = '0; ch_valid = '0; ch_mute = '0;
      underrun_clr = 1'b0; post = '0; feed_mode = 1'b1;
      for (int i = 0; i < NCH; i++) feed[i] = 8'd0;
      cycle(); cycle();
      rst = 1'b0;

      // Reset state and tick cadence
      check("rst_ready", int'(ch_ready), 15);
      check("rst_pdm", int'(pdm_sample), 0);
      first = -1; nticks = 0;
      for (int c = 1; c <= 48; c++) begin
         cycle();
         if (tick) begin nticks++; if (first < 0) first = c; end
      end
      check("first_tick_cycle", first, 15);
      check("ticks_in_48", nticks, 3);

      // Ramp up with all channels posting 200
      for (int i = 0; i < NCH; i++) feed[i] = 8'd200;
      post = '1; audio_on = 1'b1;
      run_to_tick(); cycle();
      check("ramp_first_state", int'(state), 1);
      prev = pdm_sample;
      for (int k = 1; k <= 255; k++) begin
         run_to_tick(); cycle();
         if (k == 254) check("ramp_not_on_yet", int'(state), 1);
         cycle();
         check("ramp_step", int'((pdm_sample >= prev) && (pdm_sample - prev <= 1)), 1);
         prev = pdm_sample;
      end
      check("ramp_on_state", int'(state), 2);
      after_ticks(1);
      check("ramp_settle", int'(pdm_sample), 200);

      // Mix and mute
      feed[0] = 8'd255; feed[1] = 8'd255; feed[2] = 8'd0; feed[3] = 8'd0;
      after_ticks(2);
      check("mix_avg", int'(pdm_sample), 127);
      ch_mute = 4'b0001;
      after_ticks(1);
      check("mix_mute0", int'(pdm_sample), 63);
      ch_mute = 4'b1111; post = '0;
      after_ticks(3);
      check("mix_all_muted", int'(pdm_sample), 0);
      check("muted_no_underrun", int'(underrun), 0);
      post = '1;
      for (int i = 0; i < NCH; i++) feed[i] = 8'd200;
      after_ticks(1);
      ch_mute = '0;
      after_ticks(2);

      // Handshake: one transfer per tick period on ch1
      for (int p = 0; p < 3; p++) begin
         run_to_tick(); cycle();
         cnt = 0;
         for (int c = 0; c < TICK_DIV; c++) begin
            if (ch_valid[1] && ch_ready[1]) cnt++;
            cycle();
         end
         check("xfer_per_period", cnt, 1);
      end
      post[1] = 1'b0;
      run_to_tick(); cycle();
      run_to_tick(); post[1] = 1'b1; cycle();
      check("coinc_ready_low", int'(ch_ready[1]), 0);
      repeat (8) cycle();
      check("coinc_ready_held", int'(ch_ready[1]), 0);
      run_to_tick(); cycle();
      check("ready_back", int'(ch_ready[1]), 1);
      underrun_clr = 1'b1; cycle(); underrun_clr = 1'b0;
      check("clr_after_coinc", int'(underrun), 0);

      // Underrun on ch2
      post[2] = 1'b0;
      after_ticks(2);
      check("underrun_ch2", int'(underrun), 4);
      check("hold_reused", int'(pdm_sample), 200);
      underrun_clr = 1'b1; cycle(); underrun_clr = 1'b0;
      check("underrun_cleared", int'(underrun), 0);
      run_to_tick(); underrun_clr = 1'b1; cycle(); underrun_clr = 1'b0;
      check("set_wins_clr", int'(underrun), 4);
      post[2] = 1'b1; cycle();
      underrun_clr = 1'b1; cycle(); underrun_clr = 1'b0;

      // Full ramp down, then no underrun while OFF
      audio_on = 1'b0; n = 0;
      while (state != 2'd0 && n < 400) begin run_to_tick(); cycle(); n++; end
      check("ramp_down_ticks", n, 256);
      underrun_clr = 1'b1; cycle(); underrun_clr = 1'b0;
      post = '0;
      after_ticks(3);
      check("off_no_underrun", int'(underrun), 0);
      post = '1;

      // Reversal at g=100
      audio_on = 1'b1;
      for (int k = 1; k <= 100; k++) begin run_to_tick(); cycle(); end
      audio_on = 1'b0;
      run_to_tick(); cycle();
      check("reversal_state", int'(state), 3);
      n = 0; en_at_tick = 0;
      while (state != 2'd0 && n < 300) begin
         run_to_tick(); en_at_tick = pdm_en; cycle(); n++;
      end
      check("reversal_ticks", n, 99);
      check("en_at_last_tick", en_at_tick, 1);
      check("en_after_tick", int'(pdm_en), 0);

      // Reset mid-ramp and mid-transfer
      audio_on = 1'b1;
      after_ticks(20);
      check("mid_ramp_state", int'(state), 1);
      post = '0; cycle(); post = '1;
      rst = 1'b1; cycle(); rst = 1'b0;
      check("rst_state", int'(state), 0);
      check("rst_pdm_sample", int'(pdm_sample), 0);
      check("rst_pdm_en", int'(pdm_en), 0);
      check("rst_ready_all", int'(ch_ready), 15);
      check("rst_underrun", int'(underrun), 0);
      check("rst_tick", int'(tick), 0);

      // Randomized traffic
      feed_mode = 1'b0;
      for (int c = 0; c < 8000; c++) begin
         rst          = ($urandom_range(0, 1999) == 0);
         if ($urandom_range(0, 1499) == 0) audio_on = ~audio_on;
         if ($urandom_range(0, 199) == 0) ch_mute[$urandom_range(0, NCH-1)] ^= 1'b1;
         ch_valid     = NCH'($urandom);
         ch_sample    = (NCH*DEPTH)'($urandom);
         underrun_clr = ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pdm_audio_sequencer.md
# pdm_audio_sequencer

Mixes NCH unsigned audio channels into one DEPTH-bit sample stream and paces updates with an internal sample-rate tick. Applies an anti-pop gain ramp on enable and disable. Sits between the APU channel generators and the PDM modulator, driving the modulator's `sample` and `en` inputs. Each channel gets a one-deep valid/ready mailbox, and per-channel underrun status is tracked.

## Interface
- DEPTH, 8: sample width in bits, shared with the PDM modulator.
- NCH, 4: number of channels; must be a power of two, at least 1.
- TICK_DIV, 16: clk cycles per sample tick, at least 3.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- audio_on  in  1  level; request audio output on (1) or off (0).
- ch_sample  in  NCH×DEPTH  per-channel unsigned sample.
- ch_valid  in  NCH  per-channel sample valid.
- ch_ready  out  NCH  per-channel mailbox empty; transfer occurs on valid&&ready.
- ch_mute  in  NCH  muted channel contributes 0 and never flags underrun.
- underrun_clr  in  1  pulse; clears all sticky underrun bits.
- underrun  out  NCH  sticky per-channel underrun flags.
- tick  out  1  one-cycle sample-rate strobe.
- state  out  2  FSM state: OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3.
- pdm_sample  out  DEPTH  sample to the modulator.
- pdm_en  out  1  modulator enable; equals state!=OFF.

## Operation
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 while count==TICK_DIV-1.
  - First tick occurs in the TICK_DIV-th cycle after rst deasserts.
- Mailbox, per channel: registers hold[DEPTH] and fresh.
  - ch_ready = !fresh.
  - Capture on valid&&ready: hold<=ch_sample, fresh<=1.
  - On tick without capture: fresh<=0.
  - Capture and tick in the same cycle: the tick consumes the pre-edge hold, the new value is stored, and fresh stays 1.
  - An unread hold is reused on every tick. A channel never loses its last value.
- Underrun: at a tick where state!=OFF, an unmuted channel with fresh==0 gets underrun[i]<=1.
  - underrun_clr clears all bits.
  - An underrun set and underrun_clr in the same cycle leaves the bit set (set wins).
- Mix, evaluated at tick:
  - sum = Σ (ch_mute[i] ? 0 : hold[i]), width DEPTH+log2(NCH).
  - mix_r <= sum >> log2(NCH) (average, truncating).
- Gain: register g, width DEPTH+1, range 0..2^DEPTH, where 2^DEPTH is unity.
- FSM; transitions are evaluated only at tick, and audio_on is sampled at tick only:
  - OFF: audio_on=1 → RAMP_UP, g<=1.
  - RAMP_UP:
    - audio_on=0 → RAMP_DOWN, g<=g-1.
    - Otherwise g<=g+1; if g+1==2^DEPTH → ON.
  - ON: audio_on=0 → RAMP_DOWN, g<=g-1.
  - RAMP_DOWN:
    - audio_on=1 → RAMP_UP, g<=g+1.
    - Otherwise g<=g-1; if g-1==0 → OFF.
  - Reversal mid-ramp continues from the current g with no jump.
- Output stage, in the cycle after tick: pdm_sample <= (mix_r*g)>>DEPTH.
  - The product is 2·DEPTH+1 bits. The result is ≤ mix_r, so it is truncated to DEPTH bits with no overflow.
  - pdm_sample holds between updates.
- Reset values:
  - count=0, hold=0, fresh=0 (so ch_ready all 1), underrun=0.
  - mix_r=0, g=0, state=OFF, pdm_sample=0, pdm_en=0, tick=0.
- Reset mid-ramp or mid-transfer: all of the above is restored on the next edge. Captures in the reset cycle are discarded.

## Timing
- Let tick be high in cycle T.
  - mix_r, g, state and underrun update at the end of T.
  - pdm_en changes in T+1.
  - pdm_sample changes in T+2 and reflects holds sampled in T and gain g(T+1).
- A full ramp takes 2^DEPTH ticks (ON-to-OFF is 2^DEPTH ticks).
- A channel can deliver at most one sample per tick period.
- ch_ready returns to 1 in the cycle after the tick that consumed the sample, unless a capture happened in that same tick cycle.
- No combinational path from ch_valid to ch_ready.

## Test plan
Defaults for all scenarios: DEPTH=8, NCH=4, TICK_DIV=16.
- Reset/tick: release rst, hold audio_on=0.
  - tick first high at cycle 15, then every 16 cycles.
  - pdm_en=0, pdm_sample=0, ch_ready=4'b1111, underrun=0.
- Ramp up: all channels post 200 each tick, set audio_on=1.
  - state goes 1 at the first tick, 2 after 255 ticks.
  - pdm_sample rises by at most 1 per tick and settles at 200, 2 cycles after each tick.
- Mix/mute: ON state, samples 255,255,0,0 → pdm_sample=127.
  - Mute ch0 → 63.
  - All muted → 0, with no underrun flags.
- Handshake: ch1 asserts valid continuously.
  - Exactly one transfer per tick period.
  - Capture coincident with a tick keeps ch_ready=0 for the next period.
- Underrun: while ON, stop posting ch2.
  - underrun=4'b0100 after the next tick; the old hold is reused.
  - underrun_clr clears it; set-and-clear in the same cycle leaves it set.
  - Underrun is never flagged in OFF.
- Reversal/reset: drop audio_on at g=100 during RAMP_UP.
  - RAMP_DOWN with g=99, reaching OFF after 99 more ticks; pdm_en falls in the cycle after that tick.
  - Assert rst mid-ramp: state=OFF, all outputs at reset values on the next edge.
